// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: H/V counters, sync, data-enable and
// frame markers, with a double-buffered config that only takes effect at a frame boundary.
module video_timing_gen #(
  parameter int unsigned H_W = 16,
  parameter int unsigned V_W = 13,
  parameter int unsigned F_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           cfg_load,
  input  logic [H_W-1:0] cfg_h_total,
  input  logic [H_W-1:0] cfg_h_sync,
  input  logic [H_W-1:0] cfg_h_act_start,
  input  logic [H_W-1:0] cfg_h_act_end,
  input  logic [V_W-1:0] cfg_v_total,
  input  logic [V_W-1:0] cfg_v_sync,
  input  logic [V_W-1:0] cfg_v_act_start,
  input  logic [V_W-1:0] cfg_v_act_end,
  input  logic [1:0]     cfg_pol,
  output logic           hd,
  output logic           vd,
  output logic           de,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           sof,
  output logic           eol,
  output logic [F_W-1:0] frame_cnt,
  output logic           cfg_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [H_W-1:0] h_total;
    logic [H_W-1:0] h_sync;
    logic [H_W-1:0] h_act_start;
    logic [H_W-1:0] h_act_end;
    logic [V_W-1:0] v_total;
    logic [V_W-1:0] v_sync;
    logic [V_W-1:0] v_act_start;
    logic [V_W-1:0] v_act_end;
    logic [1:0]     pol;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    h_total:     H_W'(63),
    h_sync:      H_W'(6),
    h_act_start: H_W'(7),
    h_act_end:   H_W'(63),
    v_total:     V_W'(31),
    v_sync:      V_W'(1),
    v_act_start: V_W'(1),
    v_act_end:   V_W'(31),
    pol:         2'b00
  };

  state_t         state_q, state_d;
  cfg_t           act_q, act_d;
  cfg_t           pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic [F_W-1:0] frame_cnt_q, frame_cnt_d;
  logic           hd_q, hd_d;
  logic           vd_q, vd_d;
  logic           de_q, de_d;
  logic           sof_q, sof_d;
  logic           eol_q, eol_d;
  logic           cfg_err_q, cfg_err_d;

  cfg_t cfg_in;
  logic load_ok;
  logic line_end;
  logic frame_end;
  logic apply;

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    cfg_err_d    = cfg_err_q;

    cfg_in = '{
      h_total:     cfg_h_total,
      h_sync:      cfg_h_sync,
      h_act_start: cfg_h_act_start,
      h_act_end:   cfg_h_act_end,
      v_total:     cfg_v_total,
      v_sync:      cfg_v_sync,
      v_act_start: cfg_v_act_start,
      v_act_end:   cfg_v_act_end,
      pol:         cfg_pol
    };

    load_ok = (cfg_in.h_total >= H_W'(1)) && (cfg_in.v_total >= V_W'(1)) &&
              (cfg_in.h_sync <= cfg_in.h_total) && (cfg_in.v_sync <= cfg_in.v_total) &&
              (cfg_in.h_act_start <= cfg_in.h_act_end) && (cfg_in.h_act_end <= cfg_in.h_total) &&
              (cfg_in.v_act_start <= cfg_in.v_act_end) && (cfg_in.v_act_end <= cfg_in.v_total);

    line_end  = (h_cnt_q == act_q.h_total);
    frame_end = line_end && (v_cnt_q == act_q.v_total);
    apply     = pend_valid_q && ((state_q == S_IDLE) || frame_end);

    // The applied config is the old pending one; a same-cycle load becomes the next pending.
    if (apply) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (cfg_load) begin
      cfg_err_d = !load_ok;
      if (load_ok) begin
        pend_d       = cfg_in;
        pend_valid_d = 1'b1;
      end
    end

    state_d = en ? S_RUN : S_IDLE;
    if (!en || (state_q == S_IDLE)) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end) begin
      h_cnt_d = '0;
      if (frame_end) begin
        v_cnt_d     = '0;
        frame_cnt_d = frame_cnt_q + F_W'(1);
      end else begin
        v_cnt_d = v_cnt_q + V_W'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + H_W'(1);
    end

    // Decodes are taken from next-cycle counters and config so they register in step with them.
    hd_d  = (en && (h_cnt_d < act_d.h_sync)) ^ act_d.pol[0];
    vd_d  = (en && (v_cnt_d < act_d.v_sync)) ^ act_d.pol[1];
    de_d  = en &&
            (h_cnt_d >= act_d.h_act_start) && (h_cnt_d <= act_d.h_act_end) &&
            (v_cnt_d >= act_d.v_act_start) && (v_cnt_d <= act_d.v_act_end);
    sof_d = en && (h_cnt_d == '0) && (v_cnt_d == '0);
    eol_d = en && (h_cnt_d == act_d.h_total);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      act_q        <= CFG_DEFAULT;
      pend_q       <= CFG_DEFAULT;
      pend_valid_q <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_cnt_q  <= '0;
      hd_q         <= CFG_DEFAULT.pol[0];
      vd_q         <= CFG_DEFAULT.pol[1];
      de_q         <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      hd_q         <= hd_d;
      vd_q         <= vd_d;
      de_q         <= de_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign hd        = hd_q;
  assign vd        = vd_q;
  assign de        = de_q;
  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign frame_cnt = frame_cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: directed stimulus schedules expected
// raster states by cycle number; a monitor pops and compares them as the cycles arrive.
module tb_video_timing_gen;

  localparam int unsigned H_W = 16;
  localparam int unsigned V_W = 13;
  localparam int unsigned F_W = 16;
  localparam int unsigned B   = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           cfg_load;
  logic [H_W-1:0] cfg_h_total, cfg_h_sync, cfg_h_act_start, cfg_h_act_end;
  logic [V_W-1:0] cfg_v_total, cfg_v_sync, cfg_v_act_start, cfg_v_act_end;
  logic [1:0]     cfg_pol;
  logic           hd, vd, de, sof, eol, cfg_err;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [F_W-1:0] frame_cnt;

  video_timing_gen #(.H_W(H_W), .V_W(V_W), .F_W(F_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
    .cfg_h_act_start(cfg_h_act_start), .cfg_h_act_end(cfg_h_act_end),
    .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
    .cfg_v_act_start(cfg_v_act_start), .cfg_v_act_end(cfg_v_act_end),
    .cfg_pol(cfg_pol), .hd(hd), .vd(vd), .de(de), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .sof(sof), .eol(eol), .frame_cnt(frame_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    int          h;
    int          v;
    bit          hd, vd, de, sof, eol;
    int          frame;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  function automatic void ex(int unsigned c, string n, int h, int v, bit ehd, bit evd,
                             bit ede, bit esof, bit eeol, int f, bit eerr);
    exp_t e;
    e.cyc = c; e.name = n; e.h = h; e.v = v; e.hd = ehd; e.vd = evd; e.de = ede;
    e.sof = esof; e.eol = eeol; e.frame = f; e.err = eerr;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc || int'(h_cnt) != e.h || int'(v_cnt) != e.v || hd != e.hd ||
          vd != e.vd || de != e.de || sof != e.sof || eol != e.eol ||
          int'(frame_cnt) != e.frame || cfg_err != e.err) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got h=%0d v=%0d hd=%b vd=%b de=%b sof=%b eol=%b f=%0d err=%b exp h=%0d v=%0d hd=%b vd=%b de=%b sof=%b eol=%b f=%0d err=%b",
                 e.name, cyc, h_cnt, v_cnt, hd, vd, de, sof, eol, frame_cnt, cfg_err,
                 e.h, e.v, e.hd, e.vd, e.de, e.sof, e.eol, e.frame, e.err);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s never reached (scheduled cyc=%0d, now=%0d)", e.name, e.cyc, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic goto(input int unsigned t);
    while (cyc != t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_cfg(input int unsigned t, input int ht, input int hs, input int has,
                          input int hae, input int vt, input int vs, input int vas,
                          input int vae, input logic [1:0] pol);
    goto(t - 1);
    cfg_h_total = H_W'(ht); cfg_h_sync = H_W'(hs);
    cfg_h_act_start = H_W'(has); cfg_h_act_end = H_W'(hae);
    cfg_v_total = V_W'(vt); cfg_v_sync = V_W'(vs);
    cfg_v_act_start = V_W'(vas); cfg_v_act_end = V_W'(vae);
    cfg_pol = pol;
    cfg_load = 1'b1;
    goto(t);
    cfg_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0;
    cfg_h_total = '0; cfg_h_sync = '0; cfg_h_act_start = '0; cfg_h_act_end = '0;
    cfg_v_total = '0; cfg_v_sync = '0; cfg_v_act_start = '0; cfg_v_act_end = '0;
    cfg_pol = '0;

    //  cycle      name            h   v  hd vd de sof eol f  err
    ex(2,          "rst",          0,  0, 0, 0, 0, 0, 0, 0, 0);
    ex(6,          "idle",         0,  0, 0, 0, 0, 0, 0, 0, 0);
    ex(B + 1,      "t1_sof",       0,  0, 1, 1, 0, 1, 0, 0, 0);
    ex(B + 6,      "t1_hd_last",   5,  0, 1, 1, 0, 0, 0, 0, 0);
    ex(B + 7,      "t1_hd_off",    6,  0, 0, 1, 0, 0, 0, 0, 0);
    ex(B + 64,     "t1_eol0",      63, 0, 0, 1, 0, 0, 1, 0, 0);
    ex(B + 65,     "t1_line1",     0,  1, 1, 0, 0, 0, 0, 0, 0);
    ex(B + 73,     "t1_de",        8,  1, 0, 0, 1, 0, 0, 0, 0);
    ex(B + 2048,   "t1_last",      63, 31, 0, 0, 1, 0, 1, 0, 0);
    ex(B + 2049,   "t1_f1",        0,  0, 1, 1, 0, 1, 0, 1, 0);
    ex(B + 6145,   "t1_f3",        0,  0, 1, 1, 0, 1, 0, 3, 0);
    ex(B + 7002,   "t2_pend",      25, 13, 0, 0, 1, 0, 0, 3, 0);
    ex(B + 8192,   "t2_old_end",   63, 31, 0, 0, 1, 0, 1, 3, 0);
    ex(B + 8193,   "t2_new_sof",   0,  0, 1, 1, 0, 1, 0, 4, 0);
    ex(B + 8256,   "t2_h63",       63, 0, 0, 1, 0, 0, 0, 4, 0);
    ex(B + 8292,   "t2_eol",       99, 0, 0, 1, 0, 0, 1, 4, 0);
    ex(B + 8293,   "t2_line1",     0,  1, 1, 1, 0, 0, 0, 4, 0);
    ex(B + 8413,   "t2_de_start",  20, 2, 0, 0, 1, 0, 0, 4, 0);
    ex(B + 9082,   "t2_de_end",    89, 8, 0, 0, 1, 0, 0, 4, 0);
    ex(B + 9083,   "t2_de_off",    90, 8, 0, 0, 0, 0, 0, 4, 0);
    ex(B + 9192,   "t2_frame_end", 99, 9, 0, 0, 0, 0, 1, 4, 0);
    ex(B + 9193,   "t2_f5",        0,  0, 1, 1, 0, 1, 0, 5, 0);
    ex(B + 10193,  "t3_sof",       0,  0, 0, 0, 0, 1, 0, 6, 0);
    ex(B + 10203,  "t3_hd_inact",  10, 0, 1, 0, 0, 0, 0, 6, 0);
    ex(B + 10293,  "t3_line1",     0,  1, 0, 0, 0, 0, 0, 6, 0);
    ex(B + 10413,  "t3_de",        20, 2, 1, 1, 1, 0, 0, 6, 0);
    ex(B + 10502,  "t4_err",       9,  3, 0, 1, 0, 0, 0, 6, 1);
    ex(B + 11193,  "t4_keep",      0,  0, 0, 0, 0, 1, 0, 7, 1);
    ex(B + 11292,  "t4_keep_eol",  99, 0, 1, 0, 0, 0, 1, 7, 1);
    ex(B + 11302,  "t4_clr",       9,  1, 0, 0, 0, 0, 0, 7, 0);
    ex(B + 12193,  "t4_dflt",      0,  0, 1, 1, 0, 1, 0, 8, 0);
    ex(B + 12543,  "t5_pre",       30, 5, 0, 0, 1, 0, 0, 8, 0);
    ex(B + 12544,  "t5_idle",      0,  0, 0, 0, 0, 0, 0, 8, 0);
    ex(B + 12550,  "t5_idle2",     0,  0, 0, 0, 0, 0, 0, 8, 0);
    ex(B + 12554,  "t5_resume",    0,  0, 1, 1, 0, 1, 0, 8, 0);
    ex(B + 12617,  "t5_eol",       63, 0, 0, 1, 0, 0, 1, 8, 0);
    ex(B + 12800,  "t6_rst",       0,  0, 0, 0, 0, 0, 0, 0, 0);
    ex(B + 12803,  "t6_sof",       0,  0, 1, 1, 0, 1, 0, 0, 0);
    ex(B + 12867,  "t6_line1",     0,  1, 1, 0, 0, 0, 0, 0, 0);
    ex(B + 12902,  "t6_geom",      35, 1, 0, 0, 1, 0, 0, 0, 0);
    ex(B + 14850,  "t6_end",       63, 31, 0, 0, 1, 0, 1, 0, 0);
    ex(B + 14851,  "t6_f1",        0,  0, 1, 1, 0, 1, 0, 1, 0);

    goto(4);
    rst_n = 1'b1;
    goto(B);
    en = 1'b1;

    load_cfg(B + 7000,  99, 10, 20, 89, 9, 2, 2, 8, 2'b00);
    load_cfg(B + 9300,  99, 10, 20, 89, 9, 2, 2, 8, 2'b11);
    load_cfg(B + 10500, 63, 6, 7, 70, 31, 1, 1, 31, 2'b00);
    load_cfg(B + 11300, 63, 6, 7, 63, 31, 1, 1, 31, 2'b00);

    goto(B + 12543);
    en = 1'b0;
    goto(B + 12553);
    en = 1'b1;

    load_cfg(B + 12700, 99, 10, 20, 89, 9, 2, 2, 8, 2'b00);
    goto(B + 12800);
    rst_n = 1'b0;
    goto(B + 12802);
    rst_n = 1'b1;

    goto(B + 14855);
    done = 1'b1;
  end

endmodule
